trap_ctrl: RTL and testbench

- Trap sequencer that drives the machine-mode CSR file's trap-update interface.
- Watches the writeback stage for exceptions and mret, and the interrupt lines.
- Arbitrates one trap, flushes the pipeline, then pulses the CSR update strobes.
- Issues a fetch redirect to the mtvec handler (or to mepc for mret) and waits for the fetch unit to accept it.

---
 rtl/trap_ctrl_pkg.sv | 32 +++
 rtl/trap_ctrl_cause_enc.sv | 65 ++++++
 rtl/trap_ctrl.sv | 159 +++++++++++++++
 tb/tb_trap_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared types for the machine-mode trap sequencer: cause codes, privilege
// levels, mie bit positions and sequencer states.
package trap_ctrl_pkg;

  typedef enum logic [5:0] {
    EXC_INSTR_MISALIGN = 6'd0,
    EXC_ILLEGAL        = 6'd2,
    EXC_BREAKPOINT     = 6'd3,
    EXC_ECALL_U        = 6'd8,
    EXC_ECALL_M        = 6'd11,
    INT_MSI            = 6'd35,
    INT_MTI            = 6'd39,
    INT_MEI            = 6'd43
  } mcause_e;

  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_M = 2'd3
  } privilege_e;

  localparam int BIT_MIE_MEIE = 11;
  localparam int BIT_MIE_MTIE = 7;
  localparam int BIT_MIE_MSIE = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UPDATE   = 2'd1,
    REDIRECT = 2'd2
  } trap_state_e;

endpackage

// File: rtl/trap_ctrl_cause_enc.sv
// Combinational trap priority encoder: exceptions beat interrupts, and a legal
// mret is only reported when nothing else is present in writeback.
module trap_cause_enc
  import trap_ctrl_pkg::*;
(
  input  logic       wb_valid,
  input  logic       wb_illegal,
  input  logic       wb_illegal_csr,
  input  logic       wb_misalign,
  input  logic       wb_ecall,
  input  logic       wb_ebreak,
  input  logic       wb_mret,
  input  logic       extern_intr,
  input  logic       timer_intr,
  input  logic       software_intr,
  input  privilege_e privilege_mode,
  input  logic       mstatus_mie,
  input  logic       mie_meie,
  input  logic       mie_mtie,
  input  logic       mie_msie,
  output logic       take_trap,
  output logic       is_intr,
  output logic       take_mret,
  output mcause_e    cause
);

  logic in_user;
  logic exc_illegal;
  logic intr_en;
  logic mei;
  logic msi;
  logic mti;
  logic any_exc;
  logic any_intr;

  assign in_user     = (privilege_mode == PRIV_U);
  // mret from user mode is an illegal instruction, not a return
  assign exc_illegal = wb_illegal | wb_illegal_csr | (wb_mret & in_user);
  assign intr_en     = mstatus_mie | in_user;
  assign mei         = extern_intr   & mie_meie & intr_en;
  assign msi         = software_intr & mie_msie & intr_en;
  assign mti         = timer_intr    & mie_mtie & intr_en;

  assign any_exc   = wb_valid & (wb_misalign | exc_illegal | wb_ebreak | wb_ecall);
  assign any_intr  = wb_valid & (mei | msi | mti);
  assign take_trap = any_exc | any_intr;
  assign is_intr   = any_intr & ~any_exc;
  assign take_mret = wb_valid & wb_mret & ~in_user & ~any_exc & ~any_intr;

  always_comb begin
    cause = EXC_INSTR_MISALIGN;
    if (any_exc) begin
      if (wb_misalign)      cause = EXC_INSTR_MISALIGN;
      else if (exc_illegal) cause = EXC_ILLEGAL;
      else if (wb_ebreak)   cause = EXC_BREAKPOINT;
      else if (in_user)     cause = EXC_ECALL_U;
      else                  cause = EXC_ECALL_M;
    end else if (any_intr) begin
      if (mei)      cause = INT_MEI;
      else if (msi) cause = INT_MSI;
      else          cause = INT_MTI;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: detect in IDLE, pulse CSR strobes in UPDATE, hold the fetch
// redirect in REDIRECT. Define TRAP_CTRL_INTR_SYNC_EN to 2-flop the interrupt lines.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter bit          VECTORED_EN = 1'b1,
  parameter int unsigned VEC_STRIDE  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_valid,
  input  logic [31:0] pc_wb,
  input  logic        wb_illegal,
  input  logic        wb_illegal_csr,
  input  logic        wb_misalign,
  input  logic        wb_ecall,
  input  logic        wb_ebreak,
  input  logic        wb_mret,
  input  logic        extern_intr,
  input  logic        timer_intr,
  input  logic        software_intr,
  input  privilege_e  privilege_mode,
  input  logic        mstatus_mie,
  input  logic [31:0] mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        flush,
  output logic        mcause_update,
  output logic        mepc_updata,
  output mcause_e     mcause,
  output logic [31:0] trap_pc,
  output logic        is_mret,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  logic ext_line;
  logic tim_line;
  logic sw_line;

`ifdef TRAP_CTRL_INTR_SYNC_EN
  logic [1:0] ext_sync;
  logic [1:0] tim_sync;
  logic [1:0] sw_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_sync <= 2'b00;
      tim_sync <= 2'b00;
      sw_sync  <= 2'b00;
    end else begin
      ext_sync <= {ext_sync[0], extern_intr};
      tim_sync <= {tim_sync[0], timer_intr};
      sw_sync  <= {sw_sync[0], software_intr};
    end
  end

  assign ext_line = ext_sync[1];
  assign tim_line = tim_sync[1];
  assign sw_line  = sw_sync[1];
`else
  assign ext_line = extern_intr;
  assign tim_line = timer_intr;
  assign sw_line  = software_intr;
`endif

  logic    take_trap;
  logic    is_intr;
  logic    take_mret;
  mcause_e enc_cause;

  trap_cause_enc u_enc (
    .wb_valid       (wb_valid),
    .wb_illegal     (wb_illegal),
    .wb_illegal_csr (wb_illegal_csr),
    .wb_misalign    (wb_misalign),
    .wb_ecall       (wb_ecall),
    .wb_ebreak      (wb_ebreak),
    .wb_mret        (wb_mret),
    .extern_intr    (ext_line),
    .timer_intr     (tim_line),
    .software_intr  (sw_line),
    .privilege_mode (privilege_mode),
    .mstatus_mie    (mstatus_mie),
    .mie_meie       (mie[BIT_MIE_MEIE]),
    .mie_mtie       (mie[BIT_MIE_MTIE]),
    .mie_msie       (mie[BIT_MIE_MSIE]),
    .take_trap      (take_trap),
    .is_intr        (is_intr),
    .take_mret      (take_mret),
    .cause          (enc_cause)
  );

  logic unused_bits;
  assign unused_bits = ^{mie[31:12], mie[10:8], mie[6:4], mie[2:0], mepc[0]};

  trap_state_e state_q;
  trap_state_e state_d;
  logic        detect;
  logic        mret_q;
  logic        intr_q;
  logic [31:0] target;

  assign detect = take_trap | take_mret;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (detect) state_d = UPDATE;
      UPDATE:   state_d = REDIRECT;
      REDIRECT: if (redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Vector offset only applies to interrupts with mtvec in vectored mode
  always_comb begin
    target = {mtvec[31:2], 2'b00};
    if (mret_q) begin
      target = {mepc[31:1], 1'b0};
    end else if (VECTORED_EN && intr_q && (mtvec[1:0] == 2'b01)) begin
      target = {mtvec[31:2], 2'b00} + (32'(VEC_STRIDE) * {27'd0, mcause[4:0]});
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcause      <= EXC_INSTR_MISALIGN;
      trap_pc     <= 32'd0;
      mret_q      <= 1'b0;
      intr_q      <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      if (state_q == IDLE && detect) begin
        if (take_trap) mcause <= enc_cause;
        trap_pc <= pc_wb;
        mret_q  <= take_mret;
        intr_q  <= is_intr;
      end
      if (state_q == UPDATE) redirect_pc <= target;
    end
  end

  // Gating detect with reset_n keeps flush low while reset is held
  always_comb begin
    flush          = (state_q != IDLE) | (reset_n & detect);
    mcause_update  = (state_q == UPDATE) & ~mret_q;
    mepc_updata    = (state_q == UPDATE) & ~mret_q;
    is_mret        = (state_q == UPDATE) & mret_q;
    redirect_valid = (state_q == REDIRECT);
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: trap records are queued as stimulus is
// driven and compared when the fetch redirect handshake completes.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

`ifdef TRAP_CTRL_INTR_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int W  = 71;
  localparam int CW = 80;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_valid;
  logic [31:0] pc_wb;
  logic        wb_illegal;
  logic        wb_illegal_csr;
  logic        wb_misalign;
  logic        wb_ecall;
  logic        wb_ebreak;
  logic        wb_mret;
  logic        extern_intr;
  logic        timer_intr;
  logic        software_intr;
  privilege_e  privilege_mode;
  logic        mstatus_mie;
  logic [31:0] mie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        flush;
  logic        mcause_update;
  logic        mepc_updata;
  mcause_e     mcause;
  logic [31:0] trap_pc;
  logic        is_mret;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];

  trap_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wb_valid       (wb_valid),
    .pc_wb          (pc_wb),
    .wb_illegal     (wb_illegal),
    .wb_illegal_csr (wb_illegal_csr),
    .wb_misalign    (wb_misalign),
    .wb_ecall       (wb_ecall),
    .wb_ebreak      (wb_ebreak),
    .wb_mret        (wb_mret),
    .extern_intr    (extern_intr),
    .timer_intr     (timer_intr),
    .software_intr  (software_intr),
    .privilege_mode (privilege_mode),
    .mstatus_mie    (mstatus_mie),
    .mie            (mie),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .flush          (flush),
    .mcause_update  (mcause_update),
    .mepc_updata    (mepc_updata),
    .mcause         (mcause),
    .trap_pc        (trap_pc),
    .is_mret        (is_mret),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rec(input logic kind, input logic [5:0] cause,
                                       input logic [31:0] pc, input logic [31:0] tgt);
    return {kind, cause, pc, tgt};
  endfunction

  // scoreboard: capture strobed values, compare at the redirect handshake
  logic        obs_kind  = 1'b0;
  logic [5:0]  obs_cause = 6'd0;
  logic [31:0] obs_pc    = 32'd0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mcause_update || is_mret) begin
      obs_kind  = is_mret;
      obs_cause = is_mret ? 6'd0 : mcause;
      obs_pc    = trap_pc;
    end
    if (redirect_valid && redirect_ready) begin
      check("queue_nonempty", CW'(exp_q.size() != 0), CW'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("trap_record", CW'({obs_kind, obs_cause, obs_pc, redirect_pc}), CW'(e));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    wb_valid       = 1'b0;
    wb_illegal     = 1'b0;
    wb_illegal_csr = 1'b0;
    wb_misalign    = 1'b0;
    wb_ecall       = 1'b0;
    wb_ebreak      = 1'b0;
    wb_mret        = 1'b0;
  endtask

  // Caller has just driven a trapping writeback after a posedge.
  task automatic run_trap(input logic [W-1:0] exp, input int stall, input bit inject);
    logic        kind;
    logic [31:0] hold_pc;
    kind = exp[W-1];
    exp_q.push_back(exp);
    @(negedge clk);
    check("flush_detect", CW'(flush), CW'(1));
    tick();
    clear_wb();
    @(negedge clk);
    check("update_strobes", CW'({mcause_update, mepc_updata, is_mret, flush}),
          CW'({~kind, ~kind, kind, 1'b1}));
    tick();
    if (stall == 0) redirect_ready = 1'b1;
    @(negedge clk);
    check("redirect_valid", CW'({redirect_valid, flush}), CW'(2'b11));
    hold_pc = exp[31:0];
    for (int i = 0; i < stall; i++) begin
      tick();
      if (inject) begin
        wb_valid   = 1'b1;
        wb_illegal = 1'b1;
        pc_wb      = 32'hDEAD_0000 + 32'(i);
      end
      @(negedge clk);
      check("stall_stable", CW'({redirect_valid, flush, mcause_update, redirect_pc, trap_pc}),
            CW'({1'b1, 1'b1, 1'b0, hold_pc, exp[63:32]}));
    end
    if (stall != 0) begin
      tick();
      clear_wb();
      redirect_ready = 1'b1;
      @(negedge clk);
    end
    tick();
    redirect_ready = 1'b0;
    @(negedge clk);
    check("back_idle", CW'({flush, redirect_valid}), CW'(2'b00));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [4:0] exc_pat [4] = '{5'b11011, 5'b00111, 5'b00011, 5'b00001};
  logic [5:0] exc_code[4] = '{6'd0, 6'd2, 6'd3, 6'd11};

  initial begin
    reset_n        = 1'b0;
    clear_wb();
    pc_wb          = 32'd0;
    extern_intr    = 1'b0;
    timer_intr     = 1'b0;
    software_intr  = 1'b0;
    privilege_mode = PRIV_M;
    mstatus_mie    = 1'b0;
    mie            = 32'd0;
    mtvec          = 32'h0000_0400;
    mepc           = 32'd0;
    redirect_ready = 1'b0;

    idle_cycles(3);
    @(negedge clk);
    check("reset_outputs",
          CW'({flush, mcause_update, mepc_updata, mcause, trap_pc, is_mret, redirect_valid, redirect_pc}),
          CW'(0));
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", CW'({flush, redirect_valid, mcause_update}), CW'(0));

    // illegal op, direct mtvec
    tick();
    wb_valid = 1'b1; wb_illegal = 1'b1; pc_wb = 32'h0000_0100;
    run_trap(rec(1'b0, 6'd2, 32'h100, 32'h400), 0, 1'b0);

    // timer interrupt, vectored mtvec
    tick();
    mtvec = 32'h0000_0401; mie = 32'h80; mstatus_mie = 1'b1; timer_intr = 1'b1;
    idle_cycles(SYNC_LAT + 1);
    wb_valid = 1'b1; pc_wb = 32'h0000_0300;
    run_trap(rec(1'b0, 6'h27, 32'h300, 32'h41C), 0, 1'b0);
    timer_intr = 1'b0;
    idle_cycles(3);

    // U-mode ecall with pending external interrupt; the interrupt follows
    privilege_mode = PRIV_U; mstatus_mie = 1'b0; mie = 32'h800; extern_intr = 1'b1;
    idle_cycles(SYNC_LAT + 1);
    wb_valid = 1'b1; wb_ecall = 1'b1; pc_wb = 32'h0000_0500;
    run_trap(rec(1'b0, 6'd8, 32'h500, 32'h400), 0, 1'b0);
    tick();
    wb_valid = 1'b1; pc_wb = 32'h0000_0504;
    run_trap(rec(1'b0, 6'h2B, 32'h504, 32'h42C), 0, 1'b0);
    extern_intr = 1'b0;
    idle_cycles(3);

    // legal mret in M mode
    privilege_mode = PRIV_M; mstatus_mie = 1'b1; mepc = 32'h0000_0205;
    wb_valid = 1'b1; wb_mret = 1'b1; pc_wb = 32'h0000_0600;
    run_trap(rec(1'b1, 6'd0, 32'h600, 32'h204), 0, 1'b0);

    // stalled redirect with an illegal op arriving during the stall
    tick();
    mtvec = 32'h0000_0400;
    wb_valid = 1'b1; wb_illegal = 1'b1; pc_wb = 32'h0000_0700;
    run_trap(rec(1'b0, 6'd2, 32'h700, 32'h400), 5, 1'b1);

    // mret from U mode is illegal
    tick();
    privilege_mode = PRIV_U; mstatus_mie = 1'b0; mie = 32'd0;
    wb_valid = 1'b1; wb_mret = 1'b1; pc_wb = 32'h0000_0800;
    run_trap(rec(1'b0, 6'd2, 32'h800, 32'h400), 0, 1'b0);

    // exception priority, vectored mtvec must not offset exceptions
    privilege_mode = PRIV_M; mtvec = 32'h0000_0401;
    for (int i = 0; i < 4; i++) begin
      tick();
      wb_valid = 1'b1; pc_wb = 32'h0000_0900 + 32'(i * 4);
      {wb_misalign, wb_illegal, wb_illegal_csr, wb_ebreak, wb_ecall} = exc_pat[i];
      run_trap(rec(1'b0, exc_code[i], 32'h900 + 32'(i * 4), 32'h400), 0, 1'b0);
    end

    // interrupt priority: all three lines, then MSI+MTI
    tick();
    mstatus_mie = 1'b1; mie = 32'h888;
    extern_intr = 1'b1; timer_intr = 1'b1; software_intr = 1'b1;
    idle_cycles(SYNC_LAT + 1);
    wb_valid = 1'b1; pc_wb = 32'h0000_0A00;
    run_trap(rec(1'b0, 6'h2B, 32'hA00, 32'h42C), 0, 1'b0);
    tick();
    extern_intr = 1'b0;
    idle_cycles(SYNC_LAT + 1);
    wb_valid = 1'b1; pc_wb = 32'h0000_0A04;
    run_trap(rec(1'b0, 6'h23, 32'hA04, 32'h40C), 0, 1'b0);

    // exception beats interrupt in the same cycle
    tick();
    wb_valid = 1'b1; wb_illegal = 1'b1; pc_wb = 32'h0000_0A08;
    run_trap(rec(1'b0, 6'd2, 32'hA08, 32'h400), 0, 1'b0);
    software_intr = 1'b0;

    // disabled bit, global disable, and exception without wb_valid
    tick();
    mie = 32'h808;
    idle_cycles(SYNC_LAT + 2);
    wb_valid = 1'b1; pc_wb = 32'h0000_0B00;
    @(negedge clk);
    check("mtie_masked", CW'(flush), CW'(0));
    tick();
    mie = 32'h888; mstatus_mie = 1'b0;
    @(negedge clk);
    check("mie_global_masked", CW'(flush), CW'(0));
    tick();
    timer_intr = 1'b0;
    wb_valid = 1'b0; wb_illegal = 1'b1; wb_ecall = 1'b1;
    @(negedge clk);
    check("exc_no_valid", CW'(flush), CW'(0));
    tick();
    clear_wb();
    idle_cycles(3);

    // software interrupt latency through the optional synchronizer
    mstatus_mie = 1'b1; mie = 32'h8;
    wb_valid = 1'b1; pc_wb = 32'h0000_0C00; software_intr = 1'b1;
    for (int i = 0; i < SYNC_LAT; i++) begin
      @(negedge clk);
      check("sync_delay", CW'(flush), CW'(0));
      tick();
    end
    run_trap(rec(1'b0, 6'h23, 32'hC00, 32'h40C), 0, 1'b0);
    software_intr = 1'b0;
    idle_cycles(3);

    // reset while in UPDATE
    wb_valid = 1'b1; wb_illegal = 1'b1; pc_wb = 32'h0000_0D00;
    @(negedge clk);
    check("flush_before_reset", CW'(flush), CW'(1));
    tick();
    clear_wb();
    #2 reset_n = 1'b0;
    #1;
    check("reset_in_update",
          CW'({flush, mcause_update, mepc_updata, mcause, trap_pc, is_mret, redirect_valid, redirect_pc}),
          CW'(0));
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", CW'({flush, redirect_valid, mcause_update}), CW'(0));

    check("queue_empty", CW'(exp_q.size()), CW'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
